// File: rtl/pulse_channel_pkg.sv
// Shared encodings for the second-generation tone channel: envelope states,
// waveform modes, duty selections and the duty threshold table.
package pulse_channel_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      DECAY = 2'd2
   } env_state_t;

   typedef enum logic [1:0] {
      MODE_PULSE  = 2'd0,
      MODE_SAW    = 2'd1,
      MODE_TRI    = 2'd2,
      MODE_SILENT = 2'd3
   } wave_mode_t;

   typedef enum logic [1:0] {
      DUTY_12 = 2'd0,
      DUTY_25 = 2'd1,
      DUTY_50 = 2'd2,
      DUTY_75 = 2'd3
   } duty_t;

   // Pulse is high while the top three phase bits are below this value (eighths).
   function automatic logic [2:0] duty_threshold(input logic [1:0] duty);
      logic [2:0] thr;
      unique case (duty)
         DUTY_12: thr = 3'd1;
         DUTY_25: thr = 3'd2;
         DUTY_50: thr = 3'd4;
         default: thr = 3'd6;
      endcase
      return thr;
   endfunction

endpackage

// File: rtl/channel_envelope.sv
// Per-note hold-then-decay envelope, advanced by the envelope rate strobe.
//
// state | meaning
// IDLE  | no note sounding; counters frozen
// HOLD  | envelope held at note volume; hold counts down per tick
// DECAY | envelope decrements per tick; a tick at zero ends the note
module channel_envelope
   import pulse_channel_pkg::*;
#(
   parameter int OUT_W = 9,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OUT_W-1:0] volume,
   input  logic [LEN_W-1:0] length,
   input  logic             tick,
   output logic [OUT_W-1:0] env,
   output env_state_t       state,
   output logic             active
);

   env_state_t       state_q, state_d;
   logic [OUT_W-1:0] env_q, env_d;
   logic [LEN_W-1:0] hold_q, hold_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         env_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         env_q   <= env_d;
         hold_q  <= hold_d;
      end
   end

   // A note-on swallows a coincident tick so the new note starts at full volume.
   always_comb begin
      state_d = state_q;
      env_d   = env_q;
      hold_d  = hold_q;
      if (start) begin
         env_d   = volume;
         hold_d  = length;
         state_d = (length == '0) ? DECAY : HOLD;
      end else if (tick) begin
         unique case (state_q)
            HOLD: begin
               if (hold_q != '0) hold_d = hold_q - 1'b1;
               if (hold_q <= LEN_W'(1)) state_d = DECAY;
            end
            DECAY: begin
               if (env_q != '0) env_d = env_q - 1'b1;
               else             state_d = IDLE;
            end
            default: ;
         endcase
      end
   end

   assign env    = env_q;
   assign state  = state_q;
   assign active = (state_q != IDLE);

endmodule

// File: rtl/pulse_channel_gen2.sv
// Tone channel: phase accumulator, pulse/saw/triangle shaping scaled by the
// note envelope, registered sample out plus a strobe on every phase wrap.
module pulse_channel_gen2
   import pulse_channel_pkg::*;
#(
   parameter int PHASE_W = 32,
   parameter int OUT_W   = 9,
   parameter int LEN_W   = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_note_valid,
   output logic               o_note_ready,
   input  logic [PHASE_W-1:0] i_note_delta,
   input  logic [OUT_W-1:0]   i_note_volume,
   input  logic [LEN_W-1:0]   i_note_length,
   input  logic [1:0]         i_note_duty,
   input  logic [1:0]         i_note_mode,
   input  logic               i_env_tick,
   output logic [OUT_W-1:0]   o_output,
   output logic               o_frame_pulse,
   output logic               o_active
);

   localparam int PROD_W = 2 * OUT_W;

   logic               ready_q;
   logic [PHASE_W-1:0] phase_q, delta_q;
   logic [1:0]         duty_q;
   wave_mode_t         mode_q;
   logic               frame_q;
   logic [OUT_W-1:0]   out_q;

   logic               accept, running;
   logic [OUT_W-1:0]   env;
   env_state_t         env_state;

   logic [OUT_W-1:0]   p_top, tri_base, tri_val, sample;
   logic [PROD_W-1:0]  saw_prod, tri_prod;
   logic               pulse_hi;

   assign accept  = i_note_valid & ready_q;
   assign running = (env_state != IDLE);

   channel_envelope #(
      .OUT_W (OUT_W),
      .LEN_W (LEN_W)
   ) u_env (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .start  (accept),
      .volume (i_note_volume),
      .length (i_note_length),
      .tick   (i_env_tick),
      .env    (env),
      .state  (env_state),
      .active (o_active)
   );

   // The carry out of the add lands directly in the frame strobe register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ready_q <= 1'b0;
         phase_q <= '0;
         delta_q <= '0;
         duty_q  <= DUTY_50;
         mode_q  <= MODE_PULSE;
         frame_q <= 1'b0;
         out_q   <= '0;
      end else begin
         ready_q <= 1'b1;
         if (accept) begin
            delta_q <= i_note_delta;
            duty_q  <= i_note_duty;
            mode_q  <= wave_mode_t'(i_note_mode);
            phase_q <= '0;
            frame_q <= 1'b0;
         end else if (running) begin
            {frame_q, phase_q} <= {1'b0, phase_q} + {1'b0, delta_q};
         end else begin
            frame_q <= 1'b0;
         end
         out_q <= running ? sample : '0;
      end
   end

   assign p_top    = phase_q[PHASE_W-1 -: OUT_W];
   assign tri_base = phase_q[PHASE_W-2 -: OUT_W];
   assign tri_val  = phase_q[PHASE_W-1] ? ~tri_base : tri_base;
   assign saw_prod = {{OUT_W{1'b0}}, p_top}   * {{OUT_W{1'b0}}, env};
   assign tri_prod = {{OUT_W{1'b0}}, tri_val} * {{OUT_W{1'b0}}, env};
   assign pulse_hi = (phase_q[PHASE_W-1 -: 3] < duty_threshold(duty_q));

   always_comb begin
      sample = '0;
      unique case (mode_q)
         MODE_PULSE: sample = pulse_hi ? env : '0;
         MODE_SAW:   sample = saw_prod[PROD_W-1 -: OUT_W];
         MODE_TRI:   sample = tri_prod[PROD_W-1 -: OUT_W];
         default:    sample = '0;
      endcase
   end

   assign o_note_ready  = ready_q;
   assign o_output      = out_q;
   assign o_frame_pulse = frame_q;

endmodule

// File: doc/pulse_channel_gen2.md
Name: pulse_channel_gen2

Overview:
Parametrised second-generation tone channel. It combines the phase accumulator, waveform shaping and a per-note volume envelope in one block, driven by a note-on handshake from a sequencer. It adds selectable duty cycle, sawtooth/triangle modes, a hold-then-decay envelope, phase reset on note-on and a wrap-strobe frame pulse. Its output feeds the PWM/DAC mixer stage directly.

Parameters:
PHASE_W, 32, phase accumulator width (>= OUT_W+2)
OUT_W, 9, output sample width
LEN_W, 8, hold-length counter width

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_note_valid  in  1  note-on strobe; all i_note_* fields sampled when high
o_note_ready  out  1  channel can accept a note (always 1 except during reset)
i_note_delta  in  PHASE_W  phase increment per clock
i_note_volume  in  OUT_W  initial envelope level
i_note_length  in  LEN_W  envelope ticks to hold before decay; 0 = decay immediately
i_note_duty  in  2  pulse duty: 0=12.5%, 1=25%, 2=50%, 3=75%
i_note_mode  in  2  0=pulse, 1=sawtooth, 2=triangle, 3=silent
i_env_tick  in  1  envelope rate strobe (one cycle wide, e.g. 240 Hz)
o_output  out  OUT_W  registered sample
o_frame_pulse  out  1  one-cycle strobe on phase wrap
o_active  out  1  envelope state != IDLE

Behaviour:
- Reset (i_rst_n low, async): phase=0, delta=0, env=0, hold=0, state=IDLE, duty=2, mode=0; o_output=0, o_frame_pulse=0, o_active=0, o_note_ready=0. o_note_ready=1 from the first clock after release.
- Note-on accepted when i_note_valid && o_note_ready. Next edge: latch delta/duty/mode, env<=volume, hold<=length, phase<=0, state<=HOLD (or DECAY if length==0). Retrigger in any state restarts identically.
- Phase: each clock while state!=IDLE, phase<=phase+delta mod 2^PHASE_W. In IDLE the phase freezes and the output is 0.
- o_frame_pulse=1 for exactly one clock, the cycle after the add carries out. Never asserted in IDLE or on the note-on phase reset.
- Envelope FSM, advancing only on i_env_tick:
  - IDLE: no change.
  - HOLD: hold!=0 -> hold-1. When hold reaches 0 on a tick -> DECAY.
  - DECAY: env!=0 -> env-1. When env==0 on a tick -> IDLE.
  - Note-on and i_env_tick in the same cycle: the note-on wins and the tick is dropped.
- Waveform, with P = top OUT_W bits of phase and env = current envelope:
  - Pulse: high when phase[PHASE_W-1:PHASE_W-3] < {1,2,4,6}[duty]; sample=env if high, else 0.
  - Saw: (P*env)>>OUT_W, full 2*OUT_W-bit product, truncated.
  - Triangle: T = phase MSB ? ~phase[PHASE_W-2 -: OUT_W] : phase[PHASE_W-2 -: OUT_W]; sample=(T*env)>>OUT_W.
  - Mode 3: sample=0.
- o_output registered: 1 clock latency from phase/env to output.
- o_active is high from the edge that accepts a note-on until the edge that enters IDLE.
- delta=0 with an active note: the phase holds, the output is static and there is no frame pulse.

Decomposition:
- pulse_channel_pkg holds the FSM state enum (IDLE/HOLD/DECAY), mode and duty encodings, and the duty-threshold constant table.
- One sub-module, channel_envelope, contains the FSM plus hold/env counters and o_active. Phase accumulation and waveform shaping stay in the top level.

Test Plan:
- Reset values: hold i_rst_n=0 mid-note -> o_output=0, o_active=0, o_frame_pulse=0 asynchronously. After release, o_note_ready=1 next clock and state stays IDLE.
- Pulse duty: delta=2^28 (16-clock period), volume=300, length=255, mode=0. Duty=1 gives 4 clocks at 300 then 12 at 0; duty=3 gives 12 high / 4 low. o_frame_pulse every 16 clocks.
- Envelope: volume=3, length=2, ticks every 10 clocks. HOLD for 2 ticks, env 3->2->1->0 on the next 3 ticks, o_active falls on the tick at env==0, output forced to 0.
- Length=0: the note enters DECAY directly; the first tick decrements env.
- Retrigger mid-DECAY with i_env_tick in the same cycle: env reloads to the new volume without decrement, phase=0, no frame pulse that cycle.
- Sawtooth/triangle at volume=511, delta=2^23: sawtooth ramps 0..510 and wraps; triangle peaks at 510 at phase midpoint and is symmetric. Mode 3 gives 0 throughout while o_active=1.
